// File: rtl/decode_pkg.sv
// Shared constants and types for the RV32I(+M) decode stage: opcodes,
// control-ROM indices, immediate formats and the decoded-entry record.
package decode_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [5:0] MA_BUBBLE = 6'd0;
  localparam logic [5:0] MA_ADD    = 6'd1;
  localparam logic [5:0] MA_SUB    = 6'd2;
  localparam logic [5:0] MA_AND    = 6'd3;
  localparam logic [5:0] MA_OR     = 6'd4;
  localparam logic [5:0] MA_XOR    = 6'd5;
  localparam logic [5:0] MA_SLL    = 6'd6;
  localparam logic [5:0] MA_SRL    = 6'd7;
  localparam logic [5:0] MA_SRA    = 6'd8;
  localparam logic [5:0] MA_SLT    = 6'd9;
  localparam logic [5:0] MA_SLTU   = 6'd10;
  localparam logic [5:0] MA_LOAD   = 6'd11;
  localparam logic [5:0] MA_STORE  = 6'd12;
  localparam logic [5:0] MA_BRANCH = 6'd13;
  localparam logic [5:0] MA_ADDI   = 6'd14;
  localparam logic [5:0] MA_SLTI   = 6'd15;
  localparam logic [5:0] MA_SLTIU  = 6'd16;
  localparam logic [5:0] MA_XORI   = 6'd17;
  localparam logic [5:0] MA_ORI    = 6'd18;
  localparam logic [5:0] MA_ANDI   = 6'd19;
  localparam logic [5:0] MA_SLLI   = 6'd20;
  localparam logic [5:0] MA_SRLI   = 6'd21;
  localparam logic [5:0] MA_SRAI   = 6'd22;
  localparam logic [5:0] MA_LUI    = 6'd23;
  localparam logic [5:0] MA_AUIPC  = 6'd24;
  localparam logic [5:0] MA_JAL    = 6'd25;
  localparam logic [5:0] MA_JALR   = 6'd26;
  localparam logic [5:0] MA_MUL    = 6'd27;
  localparam logic [5:0] MA_DIV    = 6'd28;
  localparam logic [5:0] MA_REM    = 6'd29;

  typedef enum logic [2:0] {
    IMM_R, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_SH
  } imm_fmt_e;

  typedef struct packed {
    logic [5:0]  mapped_address;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        illegal;
  } dec_t;

endpackage

// File: rtl/decode_map.sv
// Combinational RV32I decoder: instr -> control ROM index, immediate, illegal.
// DECODE_MEXT_EN enables MUL/DIV/DIVU/REM/REMU; otherwise funct7=0000001 OP is illegal.
module decode_map
  import decode_pkg::*;
(
  input  logic [31:0] instr,
  output logic [5:0]  mapped_address,
  output logic [31:0] imm,
  output logic        illegal
);

  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [5:0]  ma;
  logic [31:0] imm_raw;
  imm_fmt_e    fmt;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  always_comb begin
    ma  = MA_BUBBLE;
    fmt = IMM_R;
    case (opcode)
      OPC_OP: begin
        if (f7 == F7_BASE) begin
          case (f3)
            3'd0: ma = MA_ADD;
            3'd1: ma = MA_SLL;
            3'd2: ma = MA_SLT;
            3'd3: ma = MA_SLTU;
            3'd4: ma = MA_XOR;
            3'd5: ma = MA_SRL;
            3'd6: ma = MA_OR;
            3'd7: ma = MA_AND;
          endcase
        end else if (f7 == F7_ALT) begin
          if (f3 == 3'd0)      ma = MA_SUB;
          else if (f3 == 3'd5) ma = MA_SRA;
        end
`ifdef DECODE_MEXT_EN
        // MULH/MULHSU/MULHU (f3 1..3) stay illegal
        else if (f7 == F7_MULDIV) begin
          case (f3)
            3'd0:       ma = MA_MUL;
            3'd4, 3'd5: ma = MA_DIV;
            3'd6, 3'd7: ma = MA_REM;
            default:    ma = MA_BUBBLE;
          endcase
        end
`endif
      end
      OPC_OP_IMM: begin
        fmt = IMM_I;
        case (f3)
          3'd0: ma = MA_ADDI;
          3'd2: ma = MA_SLTI;
          3'd3: ma = MA_SLTIU;
          3'd4: ma = MA_XORI;
          3'd6: ma = MA_ORI;
          3'd7: ma = MA_ANDI;
          3'd1: begin
            fmt = IMM_SH;
            if (f7 == F7_BASE) ma = MA_SLLI;
          end
          3'd5: begin
            fmt = IMM_SH;
            if (f7 == F7_BASE)     ma = MA_SRLI;
            else if (f7 == F7_ALT) ma = MA_SRAI;
          end
        endcase
      end
      OPC_LOAD: begin
        fmt = IMM_I;
        if (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ma = MA_LOAD;
      end
      OPC_STORE: begin
        fmt = IMM_S;
        if (f3 inside {3'd0, 3'd1, 3'd2}) ma = MA_STORE;
      end
      OPC_BRANCH: begin
        fmt = IMM_B;
        if (!(f3 inside {3'd2, 3'd3})) ma = MA_BRANCH;
      end
      OPC_LUI:   begin fmt = IMM_U; ma = MA_LUI;   end
      OPC_AUIPC: begin fmt = IMM_U; ma = MA_AUIPC; end
      OPC_JAL:   begin fmt = IMM_J; ma = MA_JAL;   end
      OPC_JALR: begin
        fmt = IMM_I;
        if (f3 == 3'd0) ma = MA_JALR;
      end
      default: ma = MA_BUBBLE;
    endcase
  end

  always_comb begin
    case (fmt)
      IMM_I:   imm_raw = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm_raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm_raw = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm_raw = {instr[31:12], 12'b0};
      IMM_J:   imm_raw = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_SH:  imm_raw = {27'b0, instr[24:20]};
      default: imm_raw = '0;
    endcase
  end

  // every legal encoding maps to a nonzero ROM index
  assign illegal        = (ma == MA_BUBBLE);
  assign mapped_address = ma;
  assign imm            = illegal ? '0 : imm_raw;

endmodule

// File: rtl/decode_stage.sv
// Decode stage: decode_map feeding an output register plus one skid entry.
// Build option DECODE_MEXT_EN (consumed by decode_map) enables the M extension.
module decode_stage
  import decode_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  mapped_address,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [31:0] imm,
  output logic [31:0] pc_out,
  output logic        illegal,
  input  logic        flush,
  output logic [15:0] illegal_count
);

  logic [5:0]  map_ma;
  logic [31:0] map_imm;
  logic        map_ill;
  dec_t        dec, out_q, skid_q;
  logic        out_v, skid_v;
  logic [15:0] ill_cnt;
  logic        acc, take, out_free;

  decode_map u_map (
    .instr          (instr),
    .mapped_address (map_ma),
    .imm            (map_imm),
    .illegal        (map_ill)
  );

  always_comb begin
    dec.mapped_address = map_ma;
    dec.rd             = map_ill ? 5'd0 : instr[11:7];
    dec.rs1            = instr[19:15];
    dec.rs2            = instr[24:20];
    dec.imm            = map_imm;
    dec.pc             = pc_in;
    dec.illegal        = map_ill;
  end

  // in_ready is purely a function of registered skid state
  assign in_ready = !skid_v;
  assign acc      = in_valid && in_ready;
  assign take     = out_v && out_ready;
  assign out_free = !out_v || out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_v   <= 1'b0;
      skid_v  <= 1'b0;
      out_q   <= '0;
      skid_q  <= '0;
      ill_cnt <= '0;
    end else if (flush) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
    end else begin
      if (out_free) begin
        // skid is older than anything arriving now; drain it first
        if (skid_v) begin
          out_q  <= skid_q;
          out_v  <= 1'b1;
          skid_v <= 1'b0;
        end else if (acc) begin
          out_q <= dec;
          out_v <= 1'b1;
        end else begin
          out_v <= 1'b0;
        end
      end else if (acc) begin
        skid_q <= dec;
        skid_v <= 1'b1;
      end
      if (take && out_q.illegal && ill_cnt != 16'hFFFF)
        ill_cnt <= ill_cnt + 16'd1;
    end
  end

  assign out_valid      = out_v;
  assign mapped_address = out_q.mapped_address;
  assign rd             = out_q.rd;
  assign rs1            = out_q.rs1;
  assign rs2            = out_q.rs2;
  assign imm            = out_q.imm;
  assign pc_out         = out_q.pc;
  assign illegal        = out_q.illegal;
  assign illegal_count  = ill_cnt;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode table, skid ordering, flush and reset.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset, in_valid, out_ready, flush;
  logic [31:0] instr, pc_in;
  logic        in_ready, out_valid, illegal;
  logic [5:0]  mapped_address;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm, pc_out;
  logic [15:0] illegal_count;

  int checks  = 0;
  int passed  = 0;
  int exp_cnt = 0;

`ifdef DECODE_MEXT_EN
  localparam bit MEXT = 1'b1;
`else
  localparam bit MEXT = 1'b0;
`endif

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_ADDI = 32'hFFF00293;
  localparam logic [31:0] I_LUI  = 32'h123453B7;

  typedef struct {
    logic [31:0] ins;
    logic [5:0]  ma;
    logic [31:0] im;
  } vec_t;

  decode_stage dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .instr          (instr),
    .pc_in          (pc_in),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .mapped_address (mapped_address),
    .rd             (rd),
    .rs1            (rs1),
    .rs2            (rs2),
    .imm            (imm),
    .pc_out         (pc_out),
    .illegal        (illegal),
    .flush          (flush),
    .illegal_count  (illegal_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    instr = '0; pc_in = '0;
    tick(); tick();
    reset = 1'b0;
    checks++; if ({out_valid, in_ready, illegal} !== 3'b010)
      $display("FAIL reset_flags: got %b want 010", {out_valid, in_ready, illegal}); else passed++;
    checks++; if ({mapped_address, rd, rs1, rs2} !== 21'd0)
      $display("FAIL reset_fields: got %h want 0", {mapped_address, rd, rs1, rs2}); else passed++;
    checks++; if ({imm, pc_out} !== 64'd0)
      $display("FAIL reset_imm_pc: got %h want 0", {imm, pc_out}); else passed++;
    checks++; if (illegal_count !== 16'd0)
      $display("FAIL reset_count: got %0d want 0", illegal_count); else passed++;
  endtask

  task automatic test_add();
    out_ready = 1'b1; in_valid = 1'b1; instr = I_ADD; pc_in = 32'h100;
    tick();
    in_valid = 1'b0;
    checks++; if ({out_valid, mapped_address, rd, rs1, rs2} !== {1'b1, 6'd1, 5'd3, 5'd1, 5'd2})
      $display("FAIL add_fields: got %h want %h", {out_valid, mapped_address, rd, rs1, rs2},
               {1'b1, 6'd1, 5'd3, 5'd1, 5'd2}); else passed++;
    checks++; if ({imm, pc_out, illegal} !== {32'd0, 32'h100, 1'b0})
      $display("FAIL add_imm_pc: got %h/%h/%b want 0/100/0", imm, pc_out, illegal); else passed++;
    tick();
    checks++; if (out_valid !== 1'b0)
      $display("FAIL add_drain: got out_valid=%b want 0", out_valid); else passed++;
  endtask

  task automatic test_decode_table();
    vec_t v[18];
    logic [31:0] w;
    logic        e_ill;
    logic [4:0]  e_rd;
    v = '{
      '{I_ADDI,       6'd14, 32'hFFFFFFFF},
      '{32'h0020A423, 6'd12, 32'h00000008},   // sw x2,8(x1)
      '{32'hFE208EE3, 6'd13, 32'hFFFFFFFC},   // beq x1,x2,-4
      '{I_LUI,        6'd23, 32'h12345000},
      '{32'h00001097, 6'd24, 32'h00001000},   // auipc x1,1
      '{32'h001000EF, 6'd25, 32'h00000800},   // jal x1,2048
      '{32'h00008067, 6'd26, 32'h00000000},   // jalr x0,0(x1)
      '{32'hFF812183, 6'd11, 32'hFFFFFFF8},   // lw x3,-8(x2)
      '{32'h40315093, 6'd22, 32'h00000003},   // srai x1,x2,3
      '{32'h402081B3, 6'd2,  32'h00000000},   // sub
      '{32'h0020B1B3, 6'd10, 32'h00000000},   // sltu
      '{32'h40311093, 6'd0,  32'h00000000},   // slli with bad funct7
      '{32'h00000000, 6'd0,  32'h00000000},   // instr[1:0]!=11
      '{32'h0000007F, 6'd0,  32'h00000000},   // unknown opcode
      '{32'h023110B3, 6'd0,  32'h00000000},   // mulh
      '{32'h023100B3, MEXT ? 6'd27 : 6'd0, 32'h00000000},
      '{32'h023140B3, MEXT ? 6'd28 : 6'd0, 32'h00000000},
      '{32'h023160B3, MEXT ? 6'd29 : 6'd0, 32'h00000000}
    };
    out_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      in_valid = 1'b1; instr = v[i].ins; pc_in = 32'(32'h2000 + i * 4);
      tick();
      in_valid = 1'b0;
      w     = v[i].ins;
      e_ill = (v[i].ma == 6'd0);
      e_rd  = e_ill ? 5'd0 : w[11:7];
      checks++; if ({out_valid, illegal, mapped_address, rd} !== {1'b1, e_ill, v[i].ma, e_rd})
        $display("FAIL decode_%0d map: got v%b i%b ma%0d rd%0d want v1 i%b ma%0d rd%0d", i,
                 out_valid, illegal, mapped_address, rd, e_ill, v[i].ma, e_rd); else passed++;
      checks++; if ({imm, pc_out} !== {v[i].im, 32'(32'h2000 + i * 4)})
        $display("FAIL decode_%0d imm_pc: got %h/%h want %h/%h", i, imm, pc_out,
                 v[i].im, 32'(32'h2000 + i * 4)); else passed++;
      if (e_ill) exp_cnt++;
    end
    tick();
    checks++; if (illegal_count !== 16'(exp_cnt))
      $display("FAIL decode_count: got %0d want %0d", illegal_count, exp_cnt); else passed++;
  endtask

  task automatic test_illegal_count();
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h0; pc_in = 32'h500;
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if ({out_valid, illegal, illegal_count} !== {2'b11, 16'(exp_cnt)})
      $display("FAIL cnt_held: got v%b i%b cnt%0d want v1 i1 cnt%0d",
               out_valid, illegal, illegal_count, exp_cnt); else passed++;
    out_ready = 1'b1;
    tick();
    exp_cnt++;
    checks++; if ({out_valid, illegal_count} !== {1'b0, 16'(exp_cnt)})
      $display("FAIL cnt_transfer: got v%b cnt%0d want v0 cnt%0d",
               out_valid, illegal_count, exp_cnt); else passed++;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_valid = 1'b1; instr = I_ADD; pc_in = 32'h300;
    tick();
    checks++; if ({in_ready, out_valid, mapped_address} !== {2'b11, 6'd1})
      $display("FAIL b2b_first: got r%b v%b ma%0d want r1 v1 ma1",
               in_ready, out_valid, mapped_address); else passed++;
    instr = I_ADDI; pc_in = 32'h304;
    tick();
    checks++; if ({in_ready, mapped_address, pc_out} !== {1'b0, 6'd1, 32'h300})
      $display("FAIL b2b_skid_full: got r%b ma%0d pc%h want r0 ma1 pc300",
               in_ready, mapped_address, pc_out); else passed++;
    instr = I_LUI; pc_in = 32'h308;
    tick();
    checks++; if ({in_ready, out_valid, mapped_address, pc_out} !== {2'b01, 6'd1, 32'h300})
      $display("FAIL b2b_stable: got r%b v%b ma%0d pc%h want r0 v1 ma1 pc300",
               in_ready, out_valid, mapped_address, pc_out); else passed++;
    out_ready = 1'b1;
    tick();
    checks++; if ({in_ready, out_valid, mapped_address, pc_out} !== {2'b11, 6'd14, 32'h304})
      $display("FAIL b2b_second: got r%b v%b ma%0d pc%h want r1 v1 ma14 pc304",
               in_ready, out_valid, mapped_address, pc_out); else passed++;
    tick();
    in_valid = 1'b0;
    checks++; if ({out_valid, mapped_address, pc_out} !== {1'b1, 6'd23, 32'h308})
      $display("FAIL b2b_third: got v%b ma%0d pc%h want v1 ma23 pc308",
               out_valid, mapped_address, pc_out); else passed++;
    tick();
    checks++; if (out_valid !== 1'b0)
      $display("FAIL b2b_drain: got out_valid=%b want 0", out_valid); else passed++;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; instr = 32'h0; pc_in = 32'h400;
    tick();
    instr = I_ADD; pc_in = 32'h404;
    tick();
    checks++; if ({in_ready, out_valid, illegal} !== 3'b011)
      $display("FAIL flush_setup: got r%b v%b i%b want r0 v1 i1",
               in_ready, out_valid, illegal); else passed++;
    flush = 1'b1; instr = I_LUI; pc_in = 32'h408;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if ({out_valid, in_ready, illegal_count} !== {2'b01, 16'(exp_cnt)})
      $display("FAIL flush_clear: got v%b r%b cnt%0d want v0 r1 cnt%0d",
               out_valid, in_ready, illegal_count, exp_cnt); else passed++;
    out_ready = 1'b1;
    tick();
    checks++; if ({out_valid, illegal_count} !== {1'b0, 16'(exp_cnt)})
      $display("FAIL flush_dropped: got v%b cnt%0d want v0 cnt%0d",
               out_valid, illegal_count, exp_cnt); else passed++;
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b0;
    in_valid = 1'b1; instr = I_ADDI; pc_in = 32'h600;
    tick();
    instr = I_ADD; pc_in = 32'h604;
    tick();
    reset = 1'b1; flush = 1'b1; instr = I_LUI; pc_in = 32'h608;
    tick();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    exp_cnt = 0;
    checks++; if ({out_valid, in_ready, illegal} !== 3'b010)
      $display("FAIL rst_mid_flags: got %b want 010", {out_valid, in_ready, illegal}); else passed++;
    checks++; if ({mapped_address, rd, rs1, rs2, imm, pc_out} !== 85'd0)
      $display("FAIL rst_mid_fields: got %h want 0",
               {mapped_address, rd, rs1, rs2, imm, pc_out}); else passed++;
    checks++; if (illegal_count !== 16'd0)
      $display("FAIL rst_mid_count: got %0d want 0", illegal_count); else passed++;
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0)
      $display("FAIL rst_mid_dropped: got out_valid=%b want 0", out_valid); else passed++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_decode_table();
    test_illegal_count();
    test_back_to_back();
    test_flush();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
